instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-port synchronous memory. It drives the memory address, absorbs the memory's one-cycle registered read latency, and buffers fetched bytes in a small FIFO. It presents them to decode with a valid/ready handshake. It supports a PC redirect for jumps/branches and a halt input.

---
 rtl/instr_fetch.sv | 72 +++++++
 tb/tb_instr_fetch.sv | 139 +++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: issues sequential reads, absorbs one-cycle memory latency, buffers results for decode
module instr_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  halt,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, ipc_q;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dat_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] tag_q [FIFO_DEPTH];
    logic                  pop, push, issue;
    logic [CW:0]           need;
    assign mem_addr  = pc_q;
    assign mem_we    = 1'b0;
    assign out_valid = cnt_q != '0;
    assign out_instr = dat_q[rptr_q];
    assign out_pc    = tag_q[rptr_q];
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & ~redirect;
    assign need      = {1'b0, cnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue     = ~halt & ~redirect & (need < (CW+1)'(FIFO_DEPTH));
    always_comb begin
        pc_d       = redirect ? redirect_addr : issue ? pc_q + ADDR_WIDTH'(1) : pc_q;
        inflight_d = issue;
        rptr_d     = redirect ? '0 : rptr_q + PW'(pop);
        wptr_d     = redirect ? '0 : wptr_q + PW'(push);
        cnt_d      = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dat_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            if (issue) ipc_q <= pc_q;
            if (push) begin
                dat_q[wptr_q] <= mem_dout;
                tag_q[wptr_q] <= ipc_q;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch streaming, backpressure, redirect, halt and reset
module tb_instr_fetch;
    logic       clk, rst, mem_we, halt, redirect, out_valid, out_ready;
    logic [7:0] mem_addr, mem_dout, redirect_addr, out_instr, out_pc;
    logic [7:0] mem [256];
    int         n_chk, n_fail;

    instr_fetch dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
        .halt(halt), .redirect(redirect), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) mem_dout <= mem[mem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_addr = 8'h00; out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 8'(out_valid), 8'h00);
        chk("rst_instr", out_instr, 8'h00);
        chk("rst_pc", out_pc, 8'h00);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_we", 8'(mem_we), 8'h00);
        rst = 1'b0;
        // first output two cycles after reset release, then one per cycle
        step();
        chk("lat_valid1", 8'(out_valid), 8'h00);
        step();
        chk("lat_valid2", 8'(out_valid), 8'h01);
        chk("first_pc", out_pc, 8'h00);
        chk("first_instr", out_instr, 8'hA5);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("stream_valid", 8'(out_valid), 8'h01);
            chk("stream_pc", out_pc, 8'(i));
            chk("stream_instr", out_instr, 8'(i) ^ 8'hA5);
        end
        chk("stream_addr", mem_addr, 8'h07);
        // backpressure: head holds, fetch stops at 0x07
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stall_valid", 8'(out_valid), 8'h01);
            chk("stall_pc", out_pc, 8'h05);
            chk("stall_addr", mem_addr, 8'h07);
        end
        out_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            step();
            chk("drain_valid", 8'(out_valid), 8'h01);
            chk("drain_pc", out_pc, 8'(i));
            chk("drain_instr", out_instr, 8'(i) ^ 8'hA5);
        end
        // redirect to 0x40
        redirect = 1'b1; redirect_addr = 8'h40;
        step();
        redirect = 1'b0;
        chk("rd1_valid", 8'(out_valid), 8'h00);
        chk("rd1_addr", mem_addr, 8'h40);
        step();
        chk("rd2_valid", 8'(out_valid), 8'h00);
        for (int i = 8'h40; i <= 8'h43; i++) begin
            step();
            chk("rd_valid", 8'(out_valid), 8'h01);
            chk("rd_pc", out_pc, 8'(i));
            chk("rd_instr", out_instr, 8'(i) ^ 8'hA5);
        end
        // redirect near the top of the address space; pc wraps
        redirect = 1'b1; redirect_addr = 8'hFE;
        step();
        redirect = 1'b0;
        chk("wr1_valid", 8'(out_valid), 8'h00);
        step();
        chk("wr2_valid", 8'(out_valid), 8'h00);
        step(); chk("wrap_pc0", out_pc, 8'hFE); chk("wrap_instr0", out_instr, 8'h5B);
        step(); chk("wrap_pc1", out_pc, 8'hFF); chk("wrap_instr1", out_instr, 8'h5A);
        step(); chk("wrap_pc2", out_pc, 8'h00); chk("wrap_instr2", out_instr, 8'hA5);
        step(); chk("wrap_pc3", out_pc, 8'h01); chk("wrap_valid3", 8'(out_valid), 8'h01);
        // halt for 4 cycles: drains buffered/in-flight 0x02 then idles at pc 0x03
        halt = 1'b1;
        step();
        chk("halt1_valid", 8'(out_valid), 8'h01);
        chk("halt1_pc", out_pc, 8'h02);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_valid", 8'(out_valid), 8'h00);
            chk("halt_addr", mem_addr, 8'h03);
        end
        halt = 1'b0;
        step();
        chk("resume1_valid", 8'(out_valid), 8'h00);
        step();
        chk("resume_valid", 8'(out_valid), 8'h01);
        chk("resume_pc", out_pc, 8'h03);
        chk("resume_instr", out_instr, 8'hA6);
        step();
        chk("resume_pc2", out_pc, 8'h04);
        // fill the buffer, then reset mid-operation
        out_ready = 1'b0;
        step();
        chk("fill_pc", out_pc, 8'h04);
        chk("fill_valid", 8'(out_valid), 8'h01);
        rst = 1'b1;
        step();
        chk("mrst_valid", 8'(out_valid), 8'h00);
        chk("mrst_addr", mem_addr, 8'h00);
        chk("mrst_pc", out_pc, 8'h00);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("mrst_lat", 8'(out_valid), 8'h00);
        step();
        chk("mrst_first_valid", 8'(out_valid), 8'h01);
        chk("mrst_first_pc", out_pc, 8'h00);
        chk("mrst_first_instr", out_instr, 8'hA5);
        step();
        chk("mrst_next_pc", out_pc, 8'h01);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
